// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - 8-input prioritized interrupt controller with Z80-style vectored acknowledge.
// Optional build macro INTC_EDGE_EN selects edge-latched pending bits instead of level mode.
module int_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_in,
    input  logic       M1_L,
    input  logic       IORQ_L,
    input  logic       RD_L,
    input  logic       WR_L,
    input  logic [7:0] addr_bus,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       INT_L
);

    localparam logic [7:0] PORT_MASK = 8'hF0;
    localparam logic [7:0] PORT_BASE = 8'hF1;
    localparam logic [7:0] PORT_EOI  = 8'hF2;
    localparam logic [7:0] PORT_PEND = 8'hF3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK     = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] mask;
    logic [3:0] base;
    logic [7:0] pend;
    logic [2:0] win;
    logic       int_l_q;
    logic       wr_seen;

    logic       io_wr;
    logic       io_rd;
    logic       wr_stb;
    logic       wr_mask;
    logic       wr_base;
    logic       wr_eoi;
    logic       ack_cyc;
    logic [7:0] active;
    logic [2:0] prio;

    assign io_wr   = !IORQ_L && !WR_L && M1_L;
    assign io_rd   = !IORQ_L && !RD_L && M1_L;
    assign ack_cyc = !M1_L && !IORQ_L;

    // A long write strobe spans several edges; only its first edge commits.
    assign wr_stb  = io_wr && !wr_seen;
    assign wr_mask = wr_stb && (addr_bus == PORT_MASK);
    assign wr_base = wr_stb && (addr_bus == PORT_BASE);
    assign wr_eoi  = wr_stb && (addr_bus == PORT_EOI);

    assign active = pend & mask;

    always_comb begin
        prio = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                prio = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask    <= 8'h00;
            base    <= 4'h0;
            wr_seen <= 1'b0;
        end else begin
            wr_seen <= io_wr;
            if (wr_mask) begin
                mask <= data_in;
            end
            if (wr_base) begin
                base <= data_in[7:4];
            end
        end
    end

`ifdef INTC_EDGE_EN
    logic [7:0] irq_r;
    logic [7:0] clr;

    // Set is OR-ed in after the clear so a fresh rising edge wins over the clear.
    assign clr = (state == ACK && IORQ_L) ? (8'h01 << win) : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_r <= 8'h00;
            pend  <= 8'h00;
        end else begin
            irq_r <= irq_in;
            pend  <= (pend & ~clr) | (irq_in & ~irq_r);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 8'h00;
        end else begin
            pend <= irq_in;
        end
    end
`endif

    // WIN is taken from the registered PEND, so an irq_in change on the ack edge is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            win     <= 3'd0;
            int_l_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (active != 8'h00) begin
                        state   <= REQ;
                        int_l_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (active == 8'h00) begin
                        state   <= IDLE;
                        int_l_q <= 1'b1;
                    end else if (ack_cyc) begin
                        state   <= ACK;
                        win     <= prio;
                        int_l_q <= 1'b1;
                    end
                end
                ACK: begin
                    if (IORQ_L) begin
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (wr_eoi) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_l_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        if (!rst) begin
            if (state == ACK && ack_cyc) begin
                data_oe  = 1'b1;
                data_out = {base, win, 1'b0};
            end else if (io_rd) begin
                case (addr_bus)
                    PORT_MASK: begin
                        data_oe  = 1'b1;
                        data_out = mask;
                    end
                    PORT_BASE: begin
                        data_oe  = 1'b1;
                        data_out = {base, 4'h0};
                    end
                    PORT_PEND: begin
                        data_oe  = 1'b1;
                        data_out = pend;
                    end
                    default: begin
                        data_oe  = 1'b0;
                        data_out = 8'h00;
                    end
                endcase
            end
        end
    end

    assign INT_L = int_l_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic       M1_L;
    logic       IORQ_L;
    logic       RD_L;
    logic       WR_L;
    logic [7:0] addr_bus;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       INT_L;

    int n_tests = 0;
    int n_fail  = 0;

    int_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .M1_L     (M1_L),
        .IORQ_L   (IORQ_L),
        .RD_L     (RD_L),
        .WR_L     (WR_L),
        .addr_bus (addr_bus),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .INT_L    (INT_L)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic [7:0] wdata;
        logic       exp_oe;
        logic [7:0] exp_data;
    } reg_vec_t;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write_strobe(input logic [7:0] a, input logic [7:0] d);
        addr_bus = a;
        data_in  = d;
        IORQ_L   = 1'b0;
        WR_L     = 1'b0;
        tick();
        IORQ_L   = 1'b1;
        WR_L     = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        io_write_strobe(a, d);
        tick();
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
        addr_bus = a;
        IORQ_L   = 1'b0;
        RD_L     = 1'b0;
        #1;
        d        = data_out;
        oe       = data_oe;
        IORQ_L   = 1'b1;
        RD_L     = 1'b1;
        #1;
    endtask

    // Full acknowledge cycle; irq_at_ack is applied together with the ack strobes.
    task automatic do_ack(input logic [7:0] irq_at_ack, output logic [7:0] vec, output logic oe);
        M1_L   = 1'b0;
        IORQ_L = 1'b0;
        irq_in = irq_at_ack;
        tick();
        vec    = data_out;
        oe     = data_oe;
        M1_L   = 1'b1;
        IORQ_L = 1'b1;
        tick();
    endtask

    // Reference: vector = upper BASE nibble plus twice the lowest enabled request index.
    function automatic logic [7:0] model_vec(input logic [7:0] b, input logic [7:0] r, input logic [7:0] m);
        int v;
        v = b & 8'hF0;
        for (int i = 0; i < 8; i++) begin
            if (((r & m) >> i) & 1) begin
                return 8'(v + 2 * i);
            end
        end
        return 8'(v);
    endfunction

    initial begin
        reg_vec_t   tbl[$];
        logic [7:0] d;
        logic       oe;
        logic [7:0] m;
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] nr;

        rst      = 1'b1;
        irq_in   = 8'h00;
        M1_L     = 1'b1;
        IORQ_L   = 1'b1;
        RD_L     = 1'b1;
        WR_L     = 1'b1;
        addr_bus = 8'h00;
        data_in  = 8'h00;

        tbl.push_back('{8'hF0, 1'b1, 8'h5A, 1'b1, 8'h5A});
        tbl.push_back('{8'hF1, 1'b1, 8'h5A, 1'b1, 8'h50});
        tbl.push_back('{8'hF1, 1'b1, 8'hFF, 1'b1, 8'hF0});
        tbl.push_back('{8'hF0, 1'b1, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{8'hF2, 1'b1, 8'h33, 1'b0, 8'h00});
        tbl.push_back('{8'hF3, 1'b1, 8'h77, 1'b1, 8'h00});
        tbl.push_back('{8'hF1, 1'b1, 8'h0F, 1'b1, 8'h00});
        tbl.push_back('{8'hF4, 1'b1, 8'h12, 1'b0, 8'h00});
        tbl.push_back('{8'hF0, 1'b0, 8'h00, 1'b1, 8'h00});

        repeat (2) tick();
        check("rst_int_l", {7'h0, INT_L}, 8'h01);
        check("rst_oe", {7'h0, data_oe}, 8'h00);
        check("rst_data", data_out, 8'h00);
        io_read(8'hF0, d, oe);
        check("rst_read_oe", {7'h0, oe}, 8'h00);
        rst = 1'b0;
        tick();
        io_read(8'hF0, d, oe);
        check("reset_mask", d, 8'h00);
        io_read(8'hF1, d, oe);
        check("reset_base", d, 8'h00);
        tick();
        io_read(8'hF3, d, oe);
        check("reset_pend", d, 8'h00);
        tick();

        foreach (tbl[i]) begin
            if (tbl[i].wr) io_write(tbl[i].addr, tbl[i].wdata);
            io_read(tbl[i].addr, d, oe);
            check($sformatf("tbl%0d_oe", i), {7'h0, oe}, {7'h0, tbl[i].exp_oe});
            check($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
            tick();
        end

`ifdef INTC_EDGE_EN
        io_write(8'hF0, 8'h02);
        io_write(8'hF1, 8'h50);
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        tick();
        check("edge_int_l", {7'h0, INT_L}, 8'h00);
        io_read(8'hF3, d, oe);
        check("edge_pend", d, 8'h02);
        tick();
        io_read(8'hF3, d, oe);
        check("edge_pend_held", d, 8'h02);
        do_ack(8'h00, d, oe);
        check("edge_vec", d, 8'h52);
        check("edge_vec_oe", {7'h0, oe}, 8'h01);
        io_read(8'hF3, d, oe);
        check("edge_pend_clr", d, 8'h00);
        io_write(8'hF2, 8'h00);
        check("edge_idle", {7'h0, INT_L}, 8'h01);
`else
        io_write(8'hF0, 8'h04);
        io_write(8'hF1, 8'hA0);
        irq_in = 8'h04;
        tick();
        check("v1_int_early", {7'h0, INT_L}, 8'h01);
        tick();
        check("v1_int", {7'h0, INT_L}, 8'h00);
        do_ack(8'h04, d, oe);
        check("v1_vec", d, 8'hA4);
        check("v1_oe", {7'h0, oe}, 8'h01);
        check("v1_service", {7'h0, INT_L}, 8'h01);
        irq_in = 8'h00;
        tick();
        io_write(8'hF2, 8'h00);
        check("v1_idle", {7'h0, INT_L}, 8'h01);

        io_write(8'hF0, 8'hFF);
        io_write(8'hF1, 8'h30);
        irq_in = 8'h0C;
        repeat (2) tick();
        check("v2_int", {7'h0, INT_L}, 8'h00);
        do_ack(8'h0C, d, oe);
        check("v2_vec_a", d, 8'h34);
        irq_in = 8'h08;
        tick();
        io_write_strobe(8'hF2, 8'h00);
        check("v2_eoi_idle", {7'h0, INT_L}, 8'h01);
        tick();
        check("v2_rereq", {7'h0, INT_L}, 8'h00);
        do_ack(8'h08, d, oe);
        check("v2_vec_b", d, 8'h36);

        irq_in = 8'h09;
        repeat (3) tick();
        check("nest_blocked", {7'h0, INT_L}, 8'h01);
        io_write_strobe(8'hF2, 8'h00);
        check("nest_eoi_edge", {7'h0, INT_L}, 8'h01);
        tick();
        check("nest_after_eoi", {7'h0, INT_L}, 8'h00);
        io_write(8'hF2, 8'h00);
        check("eoi_in_req_ignored", {7'h0, INT_L}, 8'h00);
        do_ack(8'h09, d, oe);
        check("nest_vec", d, 8'h30);
        irq_in = 8'h00;
        tick();
        io_write(8'hF2, 8'h00);

        irq_in = 8'h04;
        repeat (2) tick();
        do_ack(8'h01, d, oe);
        check("ack_edge_irq_change", d, 8'h34);
        irq_in = 8'h00;
        tick();
        io_write(8'hF2, 8'h00);

        io_write(8'hF0, 8'h00);
        irq_in = 8'h20;
        repeat (2) tick();
        check("masked_int_l", {7'h0, INT_L}, 8'h01);
        io_read(8'hF3, d, oe);
        check("masked_pend", d, 8'h20);
        io_write(8'hF0, 8'h20);
        check("unmask_int_l", {7'h0, INT_L}, 8'h00);
        io_write_strobe(8'hF0, 8'h00);
        check("mask_clr_req_hold", {7'h0, INT_L}, 8'h00);
        tick();
        check("mask_clr_idle", {7'h0, INT_L}, 8'h01);
        irq_in = 8'h00;
        tick();

        addr_bus = 8'hF0;
        data_in  = 8'h11;
        IORQ_L   = 1'b0;
        WR_L     = 1'b0;
        tick();
        data_in  = 8'h22;
        tick();
        IORQ_L   = 1'b1;
        WR_L     = 1'b1;
        tick();
        io_read(8'hF0, d, oe);
        check("first_edge_write", d, 8'h11);
        io_write(8'hF0, 8'h00);

        for (int it = 0; it < 40; it++) begin
            m = 8'($urandom);
            b = 8'($urandom);
            r = 8'($urandom);
            if (it % 5 == 0) r = r & ~m;
            io_write(8'hF0, m);
            io_write(8'hF1, b);
            irq_in = r;
            repeat (2) tick();
            check($sformatf("rnd%0d_int", it), {7'h0, INT_L}, ((r & m) == 8'h00) ? 8'h01 : 8'h00);
            io_read(8'hF3, d, oe);
            check($sformatf("rnd%0d_pend", it), d, r);
            if ((r & m) != 8'h00) begin
                nr = 8'($urandom);
                do_ack(nr, d, oe);
                check($sformatf("rnd%0d_vec", it), d, model_vec(b, r, m));
                check($sformatf("rnd%0d_svc", it), {7'h0, INT_L}, 8'h01);
            end
            irq_in = 8'h00;
            tick();
            io_write(8'hF2, 8'h00);
            check($sformatf("rnd%0d_idle", it), {7'h0, INT_L}, 8'h01);
        end

        io_write(8'hF0, 8'hFF);
        io_write(8'hF1, 8'h30);
        irq_in = 8'h10;
        repeat (2) tick();
        M1_L   = 1'b0;
        IORQ_L = 1'b0;
        tick();
        check("rst_ack_oe_before", {7'h0, data_oe}, 8'h01);
        check("rst_ack_vec_before", data_out, 8'h38);
        rst = 1'b1;
        #1;
        check("rst_ack_oe", {7'h0, data_oe}, 8'h00);
        check("rst_ack_data", data_out, 8'h00);
        check("rst_ack_int_l", {7'h0, INT_L}, 8'h01);
        M1_L   = 1'b1;
        IORQ_L = 1'b1;
        irq_in = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        io_read(8'hF0, d, oe);
        check("rst_ack_mask", d, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 irq_in  input  8  peripheral interrupt requests, active-high, synchronous to clk; bit 0 is highest priority.
REQ-005 M1_L  input  1  CPU M1 strobe, active-low.
REQ-006 IORQ_L  input  1  CPU I/O request, active-low.
REQ-007 RD_L  input  1  CPU read strobe, active-low.
REQ-008 WR_L  input  1  CPU write strobe, active-low.
REQ-009 addr_bus  input  8  low byte of the CPU address bus, used as the I/O port number.
REQ-010 data_in  input  8  CPU write data.
REQ-011 data_out  output  8  vector or register read data; 8'h00 when data_oe=0.
REQ-012 data_oe  output  1  high while the block drives data_out.
REQ-013 INT_L  output  1  maskable interrupt request to the CPU, active-low.

Function
REQ-014 The block SHALL implement these registers: MASK at port F0 (R/W, 1 = enabled); BASE at port F1 (R/W, only bits [7:4] are stored, reads return {BASE[7:4],4'h0}); EOI at port F2 (write-only, data ignored); PEND at port F3 (read-only).
REQ-015 A register write SHALL occur on the rising edge where IORQ_L=0, WR_L=0, M1_L=1 and addr_bus matches, and only on the first such edge of each strobe.
REQ-016 A register read SHALL drive data_out with data_oe=1 combinationally while IORQ_L=0, RD_L=0, M1_L=1 and addr_bus is F0, F1 or F3.
REQ-017 The state machine SHALL have states IDLE, REQ, ACK and SERVICE.
REQ-018 IDLE -> REQ on the edge where (PEND & MASK) != 0.
REQ-019 INT_L SHALL be 0 in REQ only.
REQ-020 REQ -> IDLE if (PEND & MASK) becomes 0 before acknowledge.
REQ-021 REQ -> ACK on the edge where M1_L=0 and IORQ_L=0. On that edge the lowest set index of (PEND & MASK) SHALL be latched as WIN[2:0].
REQ-022 In ACK, data_out SHALL be {BASE[7:4], WIN, 1'b0} with data_oe=1, for as long as M1_L=0 and IORQ_L=0.
REQ-023 ACK -> SERVICE on the first edge with IORQ_L=1.
REQ-024 In SERVICE, INT_L SHALL stay 1 regardless of pending requests (no nesting).
REQ-025 SERVICE -> IDLE on an EOI write. An EOI write in any other state SHALL be ignored.
REQ-026 PEND SHALL be the irq_in value registered on each edge (level mode). A device must drop its request itself.
REQ-027 MASK and BASE writes SHALL be accepted in every state.
REQ-028 A MASK write during REQ that clears all pending-enabled bits SHALL return the machine to IDLE on the next edge.
REQ-029 If irq_in changes on the same edge as acknowledge, WIN SHALL be computed from PEND as it was before that edge.

Reset
REQ-030 While rst=1, state=IDLE, MASK=8'h00, BASE=4'h0, PEND=8'h00, WIN=3'd0, INT_L=1, data_oe=0 and data_out=8'h00.
REQ-031 Reset asserted mid-cycle (REQ, ACK or SERVICE) SHALL abandon the cycle immediately, with no vector driven after rst rises.

Configuration
REQ-032 With INTC_EDGE_EN defined, each PEND bit SHALL set on a 0->1 transition of the registered irq_in bit. The bit SHALL clear only on the ACK->SERVICE edge for index WIN. If a new rising edge arrives on the same edge as the clear, set SHALL win.
REQ-033 Without INTC_EDGE_EN, PEND SHALL follow the level behaviour of REQ-026, and no edge-detect flops SHALL exist.

Verification
REQ-034 Reset then write MASK=8'h04 and BASE=8'hA0; assert irq_in[2]; after 2 edges INT_L=0. An ack cycle (M1_L=0, IORQ_L=0) drives data_out=8'hA4 with data_oe=1.
REQ-035 Assert irq_in=8'h0C with MASK=8'hFF and BASE=8'h30; ack -> data_out=8'h34. After EOI with irq_in[2] dropped, the next ack -> 8'h36.
REQ-036 Assert irq_in[5] with MASK=8'h00 -> INT_L stays 1 and PEND reads 8'h20. Then write MASK=8'h20 -> INT_L=0 within 2 edges.
REQ-037 Enter SERVICE, then raise irq_in[0] -> INT_L stays 1 until the EOI write to F2, and goes 0 two edges later.
REQ-038 Assert rst during ACK -> data_oe=0, INT_L=1 and MASK reads 8'h00 after release.
REQ-039 (INTC_EDGE_EN) Pulse irq_in[1] for one cycle with MASK=8'h02 -> PEND=8'h02 persists; ack -> data_out={BASE[7:4],4'h2}; PEND bit 1 clears on the ACK->SERVICE edge.
